sram_responder: RTL
===================

# sram_responder

Word-organised, byte-writable memory that answers the core's instruction-memory and data-memory ports. It is the responder end of the `oe`/`web`/`addr`/`DI`/`DO` SRAM protocol the core drives, and is instantiated twice at top level: once as IM and once as DM. After reset it runs a self-clear sequence that zeroes every word. It then serves one access per cycle with one-cycle read latency and a sticky out-of-range error flag.

## Interface
- `ADDR_SIZE`, default 32: byte-address width, matching the core.
- `WORD_SIZE`, default 32: data word width.
- `BYTES`, default 4: byte lanes per word; `WORD_SIZE = 8*BYTES`.
- `DEPTH`, default 1024: number of words; a power of two, at least 2.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `oe`, input, 1: read enable from the core.
- `web`, input, `BYTES`: per-byte write enable, active low; `web[i]=0` writes byte lane i.
- `addr`, input, `ADDR_SIZE`: byte address from the core.
- `DI`, input, `WORD_SIZE`: write data, driven by the core's `DO`.
- `DO`, output, `WORD_SIZE`: read data, driving the core's `DI`.
- `init_done`, output, 1: high once the clear sequence has finished.
- `err`, output, 1: sticky flag for an out-of-range access.

## Operation
- Two-state FSM: `INIT` → `READY`. Reset forces `INIT` with clear pointer `ptr=0`.
- **INIT**
  - Each cycle writes 0 to `mem[ptr]` and increments `ptr`.
  - Moves to `READY` in the cycle after `ptr==DEPTH-1` is written.
  - All core accesses are ignored: no writes, `DO` held at 0, `err` unchanged.
- **READY**
  - Word index = `addr[$clog2(DEPTH)+1:2]`. `addr[1:0]` is ignored; no misalignment checking.
  - In range when `addr < DEPTH*BYTES`.
- **Write:** any `web` bit is 0 and the address is in range. Every lane with `web[i]=0` takes `DI[8i+7:8i]`; the other lanes are unchanged.
- **Read:** `oe=1`. `DO` is loaded in the next cycle with the word value from before this cycle's write (read-first). `oe=1` together with a write is therefore legal and returns the old data.
- **Idle:** `oe=0`. `DO` holds its last value.
- **Out of range** (any write or read):
  - The write is dropped.
  - A read loads `DO=0`.
  - `err` is set to 1 and stays set until `rst`.
- `web=all-ones` with `oe=0` is idle.

## Timing
- **Reset values:** `DO=0`, `init_done=0`, `err=0`, state `INIT`, `ptr=0`. Memory contents are undefined until the clear completes.
- **Clear duration:** `init_done` rises exactly `DEPTH` cycles after the first cycle with `rst=0`. Core accesses are accepted from that same edge onward.
- **Reset during INIT or READY:** restarts the clear from `ptr=0`. `init_done` drops on the next edge.
- **Read latency:** 1 cycle. Address at edge n gives `DO` valid after edge n+1.
- **Write:** visible to a read issued on the following cycle. Back-to-back write then read of the same word returns the new data.
- **Throughput:** one access per cycle, no stalls. There is no ready signal; the core must not access before `init_done`.

## Structure
- Package `sram_pkg` holds:
  - the state enum `sram_state_t {S_INIT, S_READY}`;
  - the localparam `WORD_IDX_W = $clog2(DEPTH)`;
  - the byte-lane helper constant `LANE_W = 8`.
- Sub-module `sram_array`: storage with one write port (address, per-lane enable, data) and one registered read port. The top level contains the FSM, the clear pointer, range checking, the write mux (clear versus core) and `err`.

## Test plan
Benches run with `DEPTH=16`.
- **Reset and clear:** hold `rst` 2 cycles, then release → `init_done=0` for 16 cycles and 1 on the 16th edge. A read of every address (0x0–0x3C) then returns 0 and `err=0`.
- **Byte write:** write `DI=0xAABBCCDD`, `web=4'b0000` to 0x8. Then write `DI=0x11223344`, `web=4'b1010` to 0x8. A read of 0x8 returns `0xAA22CC44` one cycle later.
- **Read-first with back-to-back traffic:** `oe=1` with `web=0000`, `DI=0x5`, `addr=0x4` (old value 0) → `DO=0`. A read of 0x4 on the next cycle gives `DO=0x5`.
- **Out of range:** write `addr=0x40` with `DI=0xFFFFFFFF` → `err=1`. A read of 0x40 gives `DO=0`. A read of 0x0 is unchanged. `err` stays 1 until `rst`.
- **Access during INIT:** a write of `0x1234` to 0x0 during the clear is ignored → after `init_done`, a read of 0x0 returns 0 and `err=0`.
- **Reset mid-clear:** assert `rst` at clear cycle 7 for 1 cycle → `init_done` rises exactly 16 cycles after release.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM responder slice.
package sram_pkg;

    typedef enum logic {
        S_INIT,
        S_READY
    } sram_state_t;

    localparam int unsigned DEFAULT_DEPTH = 1024;
    localparam int unsigned WORD_IDX_W    = $clog2(DEFAULT_DEPTH);
    localparam int unsigned LANE_W        = 8;

endpackage

// File: rtl/sram_responder_array.sv
// Word storage with one byte-lane write port and one registered read port.
// The read port is read-first: a same-cycle write is not visible until the next read.
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned BYTES     = 4,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BYTES-1:0]     we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic                 rzero,
    input  logic [IDX_W-1:0]     raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Byte-lane write into the storage array.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Registered read data; holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM responder: clears all words after reset, then serves one core access
// per cycle with one-cycle read latency and a sticky out-of-range flag.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned BYTES     = 4,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 oe,
    input  logic [BYTES-1:0]     web,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] DI,
    output logic [WORD_SIZE-1:0] DO,
    output logic                 init_done,
    output logic                 err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam logic [ADDR_SIZE:0] LIMIT = (ADDR_SIZE+1)'(DEPTH * BYTES);

    sram_state_t          state, state_n;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     word_idx;
    logic                 in_range;
    logic                 wr_req;
    logic [BYTES-1:0]     arr_we;
    logic [IDX_W-1:0]     arr_waddr;
    logic [WORD_SIZE-1:0] arr_wdata;
    logic                 rd_en;
    logic                 rd_zero;
    logic                 err_set;

    assign word_idx  = addr[IDX_W+OFF_W-1:OFF_W];
    assign in_range  = {1'b0, addr} < LIMIT;
    assign wr_req    = ~&web;
    assign init_done = (state == S_READY);

    // State register, clear pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            ptr   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_INIT) begin
                ptr <= ptr + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Next state plus write/read steering: clear pointer in INIT, core port in READY.
    always_comb begin
        state_n   = state;
        arr_we    = '0;
        arr_waddr = ptr;
        arr_wdata = '0;
        rd_en     = 1'b0;
        rd_zero   = 1'b0;
        err_set   = 1'b0;
        if (!rst) begin
            unique case (state)
                S_INIT: begin
                    arr_we = '1;
                    if (ptr == IDX_W'(DEPTH - 1)) begin
                        state_n = S_READY;
                    end
                end
                S_READY: begin
                    if (wr_req && in_range) begin
                        arr_we    = ~web;
                        arr_waddr = word_idx;
                        arr_wdata = DI;
                    end
                    if (oe) begin
                        rd_en   = 1'b1;
                        rd_zero = !in_range;
                    end
                    if ((wr_req || oe) && !in_range) begin
                        err_set = 1'b1;
                    end
                end
                default: state_n = S_INIT;
            endcase
        end
    end

    sram_array #(
        .WORD_SIZE (WORD_SIZE),
        .BYTES     (BYTES),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (rd_en),
        .rzero (rd_zero),
        .raddr (word_idx),
        .rdata (DO)
    );

endmodule
